// File: rtl/syscall_pkg.sv
// syscall_pkg: service codes, ASCII constants and FSM encoding shared by the syscall responder.
package syscall_pkg;

    localparam logic [31:0] PRINT_CODE_DEF = 32'd1;
    localparam logic [31:0] EXIT_CODE_DEF  = 32'd10;

    localparam logic [7:0] ASCII_ZERO    = 8'h30;
    localparam logic [7:0] ASCII_LOWER_A = 8'h61;
    localparam logic [7:0] ASCII_NEWLINE = 8'h0A;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EMIT,
        S_NL,
        S_DONE,
        S_HALT
    } state_t;

endpackage

// File: rtl/nibble_to_ascii.sv
// nibble_to_ascii: maps a 4-bit value to its lowercase ASCII hex digit.
module nibble_to_ascii
    import syscall_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [7:0] ascii_o
);

    always_comb
        ascii_o = (nibble_i < 4'd10) ? ASCII_ZERO + {4'h0, nibble_i}
                                     : ASCII_LOWER_A + {4'h0, nibble_i - 4'd10};

endmodule

// File: rtl/syscall_responder.sv
// syscall_responder: stalls the core on syscall, streams print-int as hex, halts on exit, keeps stats.
module syscall_responder
    import syscall_pkg::*;
#(
    parameter logic [31:0] PRINT_CODE   = PRINT_CODE_DEF,
    parameter logic [31:0] EXIT_CODE    = EXIT_CODE_DEF,
    parameter bit          EMIT_NEWLINE = 1'b1,
    parameter int          CNT_W        = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             sys_req,
    input  logic [31:0]      v0,
    input  logic [31:0]      a0,
    input  logic             instr_retire,
    output logic             stall,
    output logic [7:0]       char_data,
    output logic             char_valid,
    input  logic             char_ready,
    output logic             halt,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);

    state_t            state_q, state_d;
    logic [31:0]       shift_q, shift_d;
    logic [2:0]        idx_q, idx_d;
    logic [CNT_W-1:0]  cyc_q, ins_q;
    logic [7:0]        digit;
    logic              req_print, req_exit;

    nibble_to_ascii u_nib (
        .nibble_i (shift_q[31:28]),
        .ascii_o  (digit)
    );

    assign req_print = sys_req && (v0 == PRINT_CODE);
    assign req_exit  = sys_req && (v0 == EXIT_CODE);

    // Request-cycle stall is combinational so the PC holds on the syscall itself.
    always_comb begin
        halt       = (state_q == S_HALT);
        char_valid = (state_q == S_EMIT) || (state_q == S_NL);
        char_data  = (state_q == S_EMIT) ? digit :
                     (state_q == S_NL)   ? ASCII_NEWLINE : 8'h00;
        stall      = (state_q == S_IDLE) ? (req_print || req_exit) : (state_q != S_DONE);
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (req_print) begin
                    shift_d = a0;
                    idx_d   = 3'd7;
                    state_d = S_EMIT;
                end else if (req_exit) begin
                    state_d = S_HALT;
                end
            end
            S_EMIT: begin
                if (char_ready) begin
                    shift_d = shift_q << 4;
                    idx_d   = idx_q - 3'd1;
                    if (idx_q == 3'd0)
                        state_d = EMIT_NEWLINE ? S_NL : S_DONE;
                end
            end
            S_NL:    state_d = char_ready ? S_DONE : S_NL;
            S_DONE:  state_d = S_IDLE;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            cyc_q   <= '0;
            ins_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            cyc_q   <= (halt || &cyc_q) ? cyc_q : cyc_q + CNT_W'(1);
            ins_q   <= (halt || stall || !instr_retire || &ins_q) ? ins_q : ins_q + CNT_W'(1);
        end
    end

    assign cycle_count = cyc_q;
    assign instr_count = ins_q;

endmodule
